// File: rtl/tl_cntr.sv
// ----------------------------------------------------------------------------
// tl_cntr: two-road traffic light controller (Moore FSM plus dwell timer).
//
// Road A and road B take turns; whichever road is not green or yellow is red.
// Green holds for at least MIN_GREEN cycles and extends while that road's
// sensor reports traffic. Yellow holds for exactly YELLOW_CYCLES cycles and
// ignores both sensors.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   reset  in   1  synchronous, active-high reset
//   ta     in   1  traffic present on road A
//   tb     in   1  traffic present on road B
//   la     out  2  road A lamp: 00 green, 01 yellow, 10 red
//   lb     out  2  road B lamp, same encoding
//   phase  out  2  current state code (S0..S3 = 00..11)
// ----------------------------------------------------------------------------
module tl_cntr #(
    parameter int unsigned MIN_GREEN     = 3,
    parameter int unsigned YELLOW_CYCLES = 5,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ta,
    input  logic       tb,
    output logic [1:0] la,
    output logic [1:0] lb,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        S0 = 2'b00,  // A green,  B red
        S1 = 2'b01,  // A yellow, B red
        S2 = 2'b10,  // A red,    B green
        S3 = 2'b11   // A red,    B yellow
    } state_e;

    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b10;

    // Timer thresholds, expressed as the registered timer value seen on the
    // last edge of the minimum/exact dwell.
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX   = {CNT_W{1'b1}};

    state_e           r_state;
    logic [CNT_W-1:0] r_timer;
    logic [1:0]       r_la;
    logic [1:0]       r_lb;

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_timer_nxt;
    logic [1:0]       w_la_nxt;
    logic [1:0]       w_lb_nxt;
    logic             w_green_min_done;
    logic             w_yellow_done;

    assign w_green_min_done = (r_timer >= GREEN_LAST);
    assign w_yellow_done    = (r_timer == YELLOW_LAST);

    // Next-state decode. Sensors only matter in the green states.
    always_comb begin
        w_state_nxt = S0;
        case (r_state)
            S0: w_state_nxt = (!ta && w_green_min_done) ? S1 : S0;
            S1: w_state_nxt = w_yellow_done ? S2 : S1;
            S2: w_state_nxt = (!tb && w_green_min_done) ? S3 : S2;
            S3: w_state_nxt = w_yellow_done ? S0 : S3;
            default: w_state_nxt = S0;
        endcase
    end

    // Dwell timer: cleared on entry to a new state, otherwise counts up and
    // sticks at all-ones so a long green never wraps back under the minimum.
    always_comb begin
        w_timer_nxt = r_timer;
        if (w_state_nxt != r_state) begin
            w_timer_nxt = '0;
        end else if (r_timer != TIMER_MAX) begin
            w_timer_nxt = r_timer + 1'b1;
        end
    end

    // Lamp decode of the next state, so the registered lamps line up with
    // r_state on every cycle.
    always_comb begin
        w_la_nxt = LAMP_RED;
        w_lb_nxt = LAMP_RED;
        case (w_state_nxt)
            S0: begin
                w_la_nxt = LAMP_GREEN;
                w_lb_nxt = LAMP_RED;
            end
            S1: begin
                w_la_nxt = LAMP_YELLOW;
                w_lb_nxt = LAMP_RED;
            end
            S2: begin
                w_la_nxt = LAMP_RED;
                w_lb_nxt = LAMP_GREEN;
            end
            S3: begin
                w_la_nxt = LAMP_RED;
                w_lb_nxt = LAMP_YELLOW;
            end
            default: begin
                w_la_nxt = LAMP_GREEN;
                w_lb_nxt = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S0;
            r_timer <= '0;
            r_la    <= LAMP_GREEN;
            r_lb    <= LAMP_RED;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_la    <= w_la_nxt;
            r_lb    <= w_lb_nxt;
        end
    end

    assign la    = r_la;
    assign lb    = r_lb;
    assign phase = r_state;

endmodule

// File: tb/tb_tl_cntr.sv
module tb_tl_cntr;

    logic       clk;
    logic       reset;
    logic       ta;
    logic       tb;
    logic [1:0] la;
    logic [1:0] lb;
    logic [1:0] phase;

    int n_checks;
    int n_pass;

    tl_cntr #(
        .MIN_GREEN    (3),
        .YELLOW_CYCLES(5),
        .CNT_W        (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ta   (ta),
        .tb   (tb),
        .la   (la),
        .lb   (lb),
        .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lamp table per state code.
    function automatic logic [1:0] exp_la(input logic [1:0] ph);
        case (ph)
            2'b00:   exp_la = 2'b00;
            2'b01:   exp_la = 2'b01;
            default: exp_la = 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] exp_lb(input logic [1:0] ph);
        case (ph)
            2'b10:   exp_lb = 2'b00;
            2'b11:   exp_lb = 2'b01;
            default: exp_lb = 2'b10;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ta    = 1'b0;
        tb    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (la !== 2'b00) $display("FAIL reset_la edge %0d: got %b expected 00", i, la);
            else n_pass++;
            n_checks++;
            if (lb !== 2'b10) $display("FAIL reset_lb edge %0d: got %b expected 10", i, lb);
            else n_pass++;
            n_checks++;
            if (phase !== 2'b00) $display("FAIL reset_phase edge %0d: got %b expected 00", i, phase);
            else n_pass++;
        end
    endtask

    task automatic test_full_cycle();
        int dur [4];
        logic [1:0] ph;
        dur[0] = 3;
        dur[1] = 5;
        dur[2] = 3;
        dur[3] = 5;
        reset = 1'b0;
        ta    = 1'b0;
        tb    = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < dur[s]; c++) begin
                ph = 2'(s);
                n_checks++;
                if (phase !== ph) $display("FAIL cycle_phase s%0d c%0d: got %b expected %b", s, c, phase, ph);
                else n_pass++;
                n_checks++;
                if (la !== exp_la(ph)) $display("FAIL cycle_la s%0d c%0d: got %b expected %b", s, c, la, exp_la(ph));
                else n_pass++;
                n_checks++;
                if (lb !== exp_lb(ph)) $display("FAIL cycle_lb s%0d c%0d: got %b expected %b", s, c, lb, exp_lb(ph));
                else n_pass++;
                n_checks++;
                if (la === 2'b00 && lb === 2'b00) $display("FAIL cycle_both_green s%0d c%0d: got la=%b lb=%b expected one red", s, c, la, lb);
                else n_pass++;
                step();
            end
        end
        n_checks++;
        if (phase !== 2'b00) $display("FAIL cycle_wrap: got %b expected 00", phase);
        else n_pass++;
    endtask

    task automatic test_green_ext();
        logic [3:0] exp_t;
        reset = 1'b1;
        step();
        reset = 1'b0;
        ta    = 1'b1;
        tb    = 1'b0;
        for (int k = 0; k < 20; k++) begin
            exp_t = (k > 15) ? 4'd15 : 4'(k);
            n_checks++;
            if (phase !== 2'b00) $display("FAIL ext_phase c%0d: got %b expected 00", k, phase);
            else n_pass++;
            n_checks++;
            if (dut.r_timer !== exp_t) $display("FAIL ext_timer c%0d: got %0d expected %0d", k, dut.r_timer, exp_t);
            else n_pass++;
            step();
        end
        n_checks++;
        if (dut.r_timer !== 4'd15) $display("FAIL ext_sat: got %0d expected 15", dut.r_timer);
        else n_pass++;
        ta = 1'b0;
        step();
        n_checks++;
        if (phase !== 2'b01) $display("FAIL ext_exit: got %b expected 01", phase);
        else n_pass++;
    endtask

    // Entered in S1 cycle 0 with ta=0.
    task automatic test_min_green();
        tb = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (phase !== 2'b01) $display("FAIL ming_s1 c%0d: got %b expected 01", c, phase);
            else n_pass++;
            step();
        end
        for (int c = 0; c < 3; c++) begin
            if (c == 1) tb = 1'b0;
            n_checks++;
            if (phase !== 2'b10) $display("FAIL ming_s2 c%0d: got %b expected 10", c, phase);
            else n_pass++;
            step();
        end
        n_checks++;
        if (phase !== 2'b11) $display("FAIL ming_exit: got %b expected 11", phase);
        else n_pass++;
    endtask

    // Entered in S3 cycle 0.
    task automatic test_yellow();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (phase !== 2'b11) $display("FAIL yel_s3 c%0d: got %b expected 11", c, phase);
            else n_pass++;
            ta = ~ta;
            tb = ~tb;
            step();
        end
        ta = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (phase !== 2'b00) $display("FAIL yel_s0 c%0d: got %b expected 00", c, phase);
            else n_pass++;
            step();
        end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (phase !== 2'b01) $display("FAIL yel_s1 c%0d: got %b expected 01", c, phase);
            else n_pass++;
            ta = ~ta;
            tb = ~tb;
            step();
        end
        n_checks++;
        if (phase !== 2'b10) $display("FAIL yel_exit: got %b expected 10", phase);
        else n_pass++;
    endtask

    // Entered in S2 cycle 0.
    task automatic test_reset_mid_yellow();
        ta = 1'b0;
        tb = 1'b0;
        repeat (5) step();
        n_checks++;
        if (phase !== 2'b11) $display("FAIL rmy_pre_phase: got %b expected 11", phase);
        else n_pass++;
        n_checks++;
        if (dut.r_timer !== 4'd2) $display("FAIL rmy_pre_timer: got %0d expected 2", dut.r_timer);
        else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (la !== 2'b00) $display("FAIL rmy_la: got %b expected 00", la);
        else n_pass++;
        n_checks++;
        if (lb !== 2'b10) $display("FAIL rmy_lb: got %b expected 10", lb);
        else n_pass++;
        n_checks++;
        if (dut.r_timer !== 4'd0) $display("FAIL rmy_timer: got %0d expected 0", dut.r_timer);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (phase !== 2'b00) $display("FAIL rmy_s0 c%0d: got %b expected 00", c, phase);
            else n_pass++;
            step();
        end
        n_checks++;
        if (phase !== 2'b01) $display("FAIL rmy_exit: got %b expected 01", phase);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        ta       = 1'b0;
        tb       = 1'b0;
        test_reset();
        test_full_cycle();
        test_green_ext();
        test_min_green();
        test_yellow();
        test_reset_mid_yellow();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tl_cntr.md
Name: tl_cntr

Overview:
- Two-road traffic light controller: road A and road B, each with a traffic sensor.
- Moore FSM plus a dwell timer. It is built from the same flip-flop primitives as the latch/flip-flop stage and consumes them directly.
- Drives the per-road lamp codes to the display/LED stage.
- One of the two roads is always red.

Parameters:
- MIN_GREEN, 3, minimum green dwell in clock cycles (≥1).
- YELLOW_CYCLES, 5, exact yellow dwell in clock cycles (≥1).
- CNT_W, 4, timer width. Must satisfy 2^CNT_W > max(MIN_GREEN, YELLOW_CYCLES).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ta  input  1  traffic present on road A (1 = cars waiting/passing).
- tb  input  1  traffic present on road B.
- la  output  2  road A lamp: 2'b00 green, 2'b01 yellow, 2'b10 red; 2'b11 never driven.
- lb  output  2  road B lamp, same encoding.
- phase  output  2  current state code: S0=00, S1=01, S2=10, S3=11.

Behaviour:
- Single clock. Reset is synchronous and active-high: sampled only on the rising clk edge.
- Reset values, applied at the first rising edge with reset=1 and held while reset=1:
  - state S0, phase=00
  - la=00 (green), lb=10 (red)
  - timer=0
- Outputs are pure functions of the state register (Moore); no combinational path from ta/tb to la/lb/phase.
- Lamp values per state:
  - S0: la green, lb red
  - S1: la yellow, lb red
  - S2: la red, lb green
  - S3: la red, lb yellow
- Timer:
  - Counts cycles spent in the current state.
  - Cleared to 0 on the edge that enters a new state; incremented by 1 on each edge the state is held.
  - Saturates at 2^CNT_W-1, never wraps.
- Transitions, evaluated at the rising edge using the registered timer value:
  - S0→S1 when ta==0 and timer ≥ MIN_GREEN-1; otherwise stay in S0.
  - S1→S2 when timer == YELLOW_CYCLES-1, unconditionally (sensors ignored).
  - S2→S3 when tb==0 and timer ≥ MIN_GREEN-1; otherwise stay in S2.
  - S3→S0 when timer == YELLOW_CYCLES-1, unconditionally.
- Resulting dwell times:
  - Green lasts at least MIN_GREEN cycles. It extends indefinitely while its own sensor is 1 and ends on the first edge where the sensor is 0 and the minimum has elapsed.
  - Yellow lasts exactly YELLOW_CYCLES cycles.
- Sensor sampling:
  - Sensors are sampled only at clock edges.
  - A 1-cycle drop of ta to 0 after the minimum green has elapsed is enough to trigger S0→S1.
  - Sensor activity during yellow has no effect.
- Saturated timer in green: with the timer at max and the sensor still 1, stay in green; the exit condition stays true once the sensor drops.
- Reset mid-operation, in any state at any timer value: next edge forces S0 / timer 0. Lamps return to la=00, lb=10 immediately after that edge.
- Illegal state: no unreachable state exists (2-bit encoding, all 4 codes used). The default branch of the next-state logic returns to S0.
- ta and tb are assumed synchronous to clk. No internal synchronizer.

Test Plan:
- Reset hold: reset=1 for 3 edges with ta=0, tb=1 → la=00, lb=10, phase=00 on every cycle after the first edge.
- Full cycle, defaults: release reset with ta=0, tb=0 →
  - phase=00 for 3 cycles, then 01 for 5 cycles, then 10 for 3 cycles, then 11 for 5 cycles, then 00.
  - Lamps follow the state table; never both green; 2'b11 never seen.
- Green extension: ta=1 for 20 cycles after reset, then ta=0 →
  - phase stays 00 through all 20 cycles, timer saturates at 15 without wrapping.
  - Enters 01 on the first edge with ta=0.
- Minimum green enforced: ta=0 throughout, tb pulses 1→0 at cycle 1 of S2 → S2 still lasts exactly 3 cycles; tb ignored during S1.
- Yellow insensitivity: toggle ta and tb every cycle during S1 and S3 → each yellow lasts exactly 5 cycles.
- Reset mid-yellow: assert reset for 1 cycle at timer=2 of S3 → next cycle phase=00, la=00, lb=10, and S0 dwell restarts its count from 0.
